bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master, one-slave arbiter between the CPU's instruction-fetch port and data-memory port on one side and the shared memory-unit bus on the other. It accepts the start/done handshake the CPU stages drive, latches the winning request, runs a single transaction on the memory bus and returns read data with a one-cycle done pulse to the winning master. Simultaneous requests are resolved round-robin so neither stage starves.

## Interface
- DATA_FIRST, 1: on reset the data port wins the first simultaneous request (round-robin pointer reset value).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- i_addr  in  32  instruction-fetch address (read-only port)
- i_start  in  1  fetch request; held high until i_done
- i_q  out  32  read data, valid only while i_done=1
- i_done  out  1  one-cycle completion pulse to fetch port
- d_addr  in  32  data-port address
- d_data  in  32  data-port write data
- d_we  in  1  data-port write enable
- d_start  in  1  data request; held high until d_done
- d_q  out  32  read data, valid only while d_done=1
- d_done  out  1  one-cycle completion pulse to data port
- mem_addr  out  32  latched transaction address
- mem_data  out  32  latched write data
- mem_we  out  1  latched write enable (0 for fetch transactions)
- mem_start  out  1  transaction request to memory unit
- mem_q  in  32  memory read data, valid with mem_done
- mem_done  in  1  one-cycle completion from memory unit

## Operation
- States: IDLE, BUSY, RESP. Registers: owner (I/D), last (I/D), addr/data/we latches, q register.
- Arbitration occurs in IDLE and RESP. Sole requester wins. Both requesting: grant the port not equal to last; grant updates last.
- On grant: latch addr (and data/we for D; we forced 0 for I), set owner, go BUSY.
- No request in IDLE: stay IDLE. No request in RESP: go IDLE.
- BUSY: mem_start = 1 and !mem_done (combinational, so start drops in the done cycle). On mem_done: capture mem_q into q register, go RESP.
- RESP: exactly one of i_done/d_done high per owner; i_q and d_q both driven from q register (zero when not in RESP).
- Requester's start in RESP is low (master deasserts on done), so the other master can be granted directly from RESP.
- mem_done outside BUSY is ignored. Master start deasserting while BUSY is not supported; the transaction completes and the done pulse is still issued.
- Write transactions also return mem_q in q; masters ignore it.

## Timing
- Reset: state IDLE; last = I if DATA_FIRST=1 else D; i_done, d_done, mem_start, mem_we = 0; i_q, d_q, mem_addr, mem_data = 0.
- Reset mid-transaction: next cycle IDLE, mem_start low; no done pulse issued; in-flight mem_done ignored.
- Request sampled at edge N -> mem_start high in cycle N+1.
- mem_done in cycle K -> master done pulse and q valid in cycle K+1 (one register stage).
- Minimum turnaround: request to done = 2 cycles + memory latency; back-to-back alternating grants with no IDLE bubble.
- mem_addr/data/we stable for the whole BUSY period regardless of master input changes.

## Test plan
- Single fetch: i_addr=0x100, i_start high; slave returns mem_q=0xDEADBEEF after 3 cycles -> mem_start high 3 cycles, mem_we=0, i_done one cycle later with i_q=0xDEADBEEF, d_done never high.
- Single write: d_addr=0x2000, d_data=0x12345678, d_we=1 -> mem_addr/mem_data/mem_we match, d_done pulses once, mem_start low in the mem_done cycle.
- Simultaneous requests after reset (DATA_FIRST=1), both held -> D granted first, I granted from RESP with no IDLE cycle; order D,I,D,I while both keep requesting.
- Input change during BUSY: d_addr switched 0x40->0x80 mid-transaction -> mem_addr stays 0x40.
- Reset asserted in BUSY with mem_done arriving next cycle -> no i_done/d_done, state IDLE, mem_start 0.
- Spurious mem_done in IDLE -> no done pulse, outputs unchanged.

Source files
------------

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Two-master / one-slave arbiter. It sits between the CPU's
//            instruction-fetch port (read only) and data port on one side and
//            the shared memory-unit bus on the other. The winning request is
//            latched, one transaction runs on the memory bus, and the read data
//            returns with a one-cycle done pulse to the winner. When both
//            masters request at once, the grant goes round-robin.
// Ports    : clk, reset              clock, synchronous active-high reset
//            i_addr/i_start          fetch request       -> i_q/i_done
//            d_addr/d_data/d_we/
//            d_start                 data request        -> d_q/d_done
//            mem_addr/mem_data/
//            mem_we/mem_start        memory request      <- mem_q/mem_done
// Params   : DATA_FIRST  1 = the data port wins the first simultaneous request
// Revision : 1.0  initial release
// ============================================================================
module bus_arbiter #(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    // instruction-fetch master
    input  logic [31:0] i_addr,
    input  logic        i_start,
    output logic [31:0] i_q,
    output logic        i_done,
    // data master
    input  logic [31:0] d_addr,
    input  logic [31:0] d_data,
    input  logic        d_we,
    input  logic        d_start,
    output logic [31:0] d_q,
    output logic        d_done,
    // memory-unit slave
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_we,
    output logic        mem_start,
    input  logic [31:0] mem_q,
    input  logic        mem_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic c_own_i    = 1'b0;
    localparam logic c_own_d    = 1'b1;
    // "last" starts on the opposite port so that the preferred port wins first
    localparam logic c_last_rst = DATA_FIRST ? c_own_i : c_own_d;

    state_t      state_q;
    logic        owner_q;
    logic        last_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        we_q;
    logic [31:0] q_q;
    logic        i_done_q;
    logic        d_done_q;

    logic        w_req;
    logic        w_pick_data;

    // A sole requester wins; with two requesters the port that was not
    // granted last time wins.
    assign w_req       = i_start | d_start;
    assign w_pick_data = d_start & (~i_start | (last_q == c_own_i));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= c_own_i;
            last_q   <= c_last_rst;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            q_q      <= '0;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
        end else begin
            // Done pulses and read data live for exactly one cycle (RESP);
            // everywhere else they return to zero.
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            q_q      <= '0;
            case (state_q)
                // A new grant may be made from RESP as well, so back-to-back
                // transactions need no IDLE bubble.
                ST_IDLE, ST_RESP: begin
                    if (w_req) begin
                        state_q <= ST_BUSY;
                        owner_q <= w_pick_data;
                        last_q  <= w_pick_data;
                        if (w_pick_data) begin
                            addr_q <= d_addr;
                            data_q <= d_data;
                            we_q   <= d_we;
                        end else begin
                            addr_q <= i_addr;
                            we_q   <= 1'b0;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                // Address/data/we stay latched for the whole transaction,
                // whatever the masters do with their inputs meanwhile.
                ST_BUSY: begin
                    if (mem_done) begin
                        state_q  <= ST_RESP;
                        q_q      <= mem_q;
                        i_done_q <= (owner_q == c_own_i);
                        d_done_q <= (owner_q == c_own_d);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Start drops in the same cycle the memory reports done, so the memory
    // unit never sees a request for a second transaction it was not given.
    assign mem_start = (state_q == ST_BUSY) && !mem_done;
    assign mem_addr  = addr_q;
    assign mem_data  = data_q;
    assign mem_we    = we_q;

    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign i_q       = q_q;
    assign d_q       = q_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Self-checking bench for bus_arbiter. Expected transactions are
//            queued as stimulus is applied; a behavioural memory slave answers
//            the DUT and each done pulse is checked against the queue head.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_addr;
    logic        i_start;
    logic [31:0] i_q;
    logic        i_done;
    logic [31:0] d_addr;
    logic [31:0] d_data;
    logic        d_we;
    logic        d_start;
    logic [31:0] d_q;
    logic        d_done;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;
    logic        mem_start;
    logic [31:0] mem_q;
    logic        mem_done;

    bus_arbiter #(.DATA_FIRST(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_addr    (i_addr),
        .i_start   (i_start),
        .i_q       (i_q),
        .i_done    (i_done),
        .d_addr    (d_addr),
        .d_data    (d_data),
        .d_we      (d_we),
        .d_start   (d_start),
        .d_q       (d_q),
        .d_done    (d_done),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_we    (mem_we),
        .mem_start (mem_start),
        .mem_q     (mem_q),
        .mem_done  (mem_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        logic [31:0] data;
        bit          we;
        logic [31:0] q;
    } txn_t;

    txn_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int lat      = 3;
    int cnt      = 0;
    int n_done   = 0;
    int done_cyc = 0;
    bit in_txn   = 1'b0;
    bit bubble   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic bit pending(input bit is_d);
        foreach (exp_q[k]) if (exp_q[k].is_d == is_d) return 1'b1;
        return 1'b0;
    endfunction

    function automatic txn_t mk(input bit is_d, input logic [31:0] a, input logic [31:0] dt,
                                input bit we, input logic [31:0] q);
        txn_t t;
        t.is_d = is_d; t.addr = a; t.data = dt; t.we = we; t.q = q;
        return t;
    endfunction

    // One clock of bench activity at the falling edge: completion monitor,
    // master behaviour (drop start on done) and the memory slave model.
    task automatic step();
        txn_t e;
        @(negedge clk);
        if (bubble) begin
            check("no_bubble_start", 32'(mem_start), 32'd1);
            bubble = 1'b0;
        end
        if (i_done || d_done) begin
            n_done++;
            done_cyc = cyc;
            check("single_done", 32'(i_done & d_done), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("done_owner", 32'(d_done), 32'(e.is_d));
                check("rdata", e.is_d ? d_q : i_q, e.q);
                if (!pending(1'b0)) i_start = 1'b0;
                if (!pending(1'b1)) d_start = 1'b0;
                if (exp_q.size() > 0) bubble = 1'b1;
            end
        end else begin
            check("q_idle_zero", i_q | d_q, 32'd0);
        end
        if (mem_done) begin
            mem_done = 1'b0;
        end else if (mem_start || in_txn) begin
            if (!in_txn) begin
                in_txn = 1'b1;
                cnt    = 0;
            end
            check("start_held", 32'(mem_start), 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_start", 32'd1, 32'd0);
            end else begin
                check("mem_addr", mem_addr, exp_q[0].addr);
                check("mem_we", 32'(mem_we), 32'(exp_q[0].we));
                if (exp_q[0].we) check("mem_data", mem_data, exp_q[0].data);
            end
            cnt++;
            if (cnt >= lat) begin
                mem_q    = (exp_q.size() > 0) ? exp_q[0].q : 32'h0;
                mem_done = 1'b1;
                in_txn   = 1'b0;
                #1;
                check("start_drop_on_done", 32'(mem_start), 32'd0);
            end
        end
    endtask

    task automatic wait_done(input int target);
        int budget;
        budget = 200;
        while (n_done < target && budget > 0) begin
            step();
            budget--;
        end
        if (n_done < target) check("done_timeout", 32'(n_done), 32'(target));
    endtask

    task automatic both_alternate();
        int base;
        base = n_done;
        lat  = 2;
        i_addr = 32'h0000_0104;
        d_addr = 32'h0000_3000; d_data = 32'hCAFE_F00D; d_we = 1'b1;
        exp_q.push_back(mk(1'b1, 32'h3000, 32'hCAFE_F00D, 1'b1, 32'h1111_0001));
        exp_q.push_back(mk(1'b0, 32'h0104, 32'h0,         1'b0, 32'h2222_0002));
        exp_q.push_back(mk(1'b1, 32'h3000, 32'hCAFE_F00D, 1'b1, 32'h3333_0003));
        exp_q.push_back(mk(1'b0, 32'h0104, 32'h0,         1'b0, 32'h4444_0004));
        i_start = 1'b1;
        d_start = 1'b1;
        wait_done(base + 4);
        repeat (3) step();
        check("alt_queue_empty", 32'(exp_q.size()), 32'd0);
        check("alt_idle_start", 32'(mem_start), 32'd0);
    endtask

    initial begin : main
        int req_cyc;
        int base;
        reset = 1'b1;
        i_addr = '0; i_start = 1'b0;
        d_addr = '0; d_data = '0; d_we = 1'b0; d_start = 1'b0;
        mem_q = '0; mem_done = 1'b0;
        repeat (2) step();
        check("rst_i_done",   32'(i_done),    32'd0);
        check("rst_d_done",   32'(d_done),    32'd0);
        check("rst_mem_start",32'(mem_start), 32'd0);
        check("rst_mem_we",   32'(mem_we),    32'd0);
        check("rst_i_q",      i_q,            32'd0);
        check("rst_d_q",      d_q,            32'd0);
        check("rst_mem_addr", mem_addr,       32'd0);
        check("rst_mem_data", mem_data,       32'd0);
        reset = 1'b0;
        step();

        // simultaneous requests right after reset: D, I, D, I
        both_alternate();

        // single fetch, 3-cycle memory
        lat = 3;
        base = n_done;
        i_addr = 32'h0000_0100;
        exp_q.push_back(mk(1'b0, 32'h0100, 32'h0, 1'b0, 32'hDEAD_BEEF));
        i_start = 1'b1;
        req_cyc = cyc;
        wait_done(base + 1);
        check("fetch_latency", 32'(done_cyc - req_cyc), 32'(lat + 1));
        repeat (2) step();
        check("fetch_one_done", 32'(n_done - base), 32'd1);

        // single write
        base = n_done;
        d_addr = 32'h0000_2000; d_data = 32'h1234_5678; d_we = 1'b1;
        exp_q.push_back(mk(1'b1, 32'h2000, 32'h1234_5678, 1'b1, 32'h0BAD_CAFE));
        d_start = 1'b1;
        wait_done(base + 1);
        repeat (2) step();
        check("write_one_done", 32'(n_done - base), 32'd1);

        // master inputs change during BUSY: latched values must hold
        lat = 5;
        base = n_done;
        d_addr = 32'h0000_0040; d_data = 32'hAAAA_0000; d_we = 1'b0;
        exp_q.push_back(mk(1'b1, 32'h0040, 32'hAAAA_0000, 1'b0, 32'h5A5A_A5A5));
        d_start = 1'b1;
        repeat (2) step();
        d_addr = 32'h0000_0080; d_data = 32'h5555_FFFF; d_we = 1'b1;
        wait_done(base + 1);
        repeat (2) step();

        // spurious mem_done while idle
        base = n_done;
        mem_q = 32'hFFFF_0000;
        mem_done = 1'b1;
        repeat (3) step();
        check("spur_no_done", 32'(n_done - base), 32'd0);
        check("spur_mem_start", 32'(mem_start), 32'd0);
        check("spur_mem_addr", mem_addr, 32'h0000_0040);
        check("spur_mem_we", 32'(mem_we), 32'd0);

        // reset in BUSY with the memory completing one cycle later
        lat = 20;
        base = n_done;
        i_addr = 32'h0000_0500;
        exp_q.push_back(mk(1'b0, 32'h0500, 32'h0, 1'b0, 32'h7777_7777));
        i_start = 1'b1;
        repeat (3) step();
        reset = 1'b1;
        i_start = 1'b0;
        exp_q.delete();
        in_txn = 1'b0;
        step();
        check("rstbusy_mem_start", 32'(mem_start), 32'd0);
        check("rstbusy_mem_addr", mem_addr, 32'd0);
        mem_q = 32'h9999_9999;
        mem_done = 1'b1;
        reset = 1'b0;
        repeat (4) step();
        check("rstbusy_no_done", 32'(n_done - base), 32'd0);
        check("rstbusy_idle_start", 32'(mem_start), 32'd0);

        // round-robin pointer restored by the reset: D wins first again
        both_alternate();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
